// File: rtl/sb_cfg_loader.sv
// -----------------------------------------------------------------------------
// sb_cfg_loader
//
// Configuration loader for the switch_box routing fabric. It receives a framed,
// byte-wide bitstream over a valid/ready handshake, assembles the payload in a
// shadow register, checks it against an XOR checksum and commits it atomically
// to the dir/en buses that drive NUM_SB switch boxes.
//
// Frame: SYNC, PAY_B payload bytes (LSB-first bit stream), checksum byte
// (XOR of the payload bytes). Switch box k occupies payload bits
// [12k+11:12k] = {en[5:0], dir[5:0]}. Pad bits above NUM_SB*12 are ignored.
//
// Ports
//   clk        in   1          system clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   cfg_valid  in   1          input byte valid
//   cfg_ready  out  1          loader can accept a byte
//   cfg_data   in   8          stream byte
//   cfg_abort  in   1          discard the frame in progress
//   dir_bus    out  NUM_SB*6   dir[5:0] of switch box k at [6k+5:6k]
//   en_bus     out  NUM_SB*6   en[5:0]  of switch box k at [6k+5:6k]
//   cfg_done   out  1          1-cycle pulse: frame committed
//   cfg_err    out  1          1-cycle pulse: checksum mismatch, frame dropped
//
// Optional feature (macro SB_CFG_READBACK_EN):
//   rb_req     in   1          request a readback of the committed buses
//   rb_valid   out  1          readback byte valid
//   rb_ready   in   1          readback consumer ready
//   rb_data    out  8          readback byte (payload bytes, then checksum)
// -----------------------------------------------------------------------------
module sb_cfg_loader #(
    parameter int         NUM_SB = 4,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [7:0]            cfg_data,
    input  logic                  cfg_abort,
    output logic [NUM_SB*6-1:0]   dir_bus,
    output logic [NUM_SB*6-1:0]   en_bus,
    output logic                  cfg_done,
    output logic                  cfg_err
`ifdef SB_CFG_READBACK_EN
    ,
    input  logic                  rb_req,
    output logic                  rb_valid,
    input  logic                  rb_ready,
    output logic [7:0]            rb_data
`endif
);

    localparam int PAY_B = (NUM_SB * 12 + 7) / 8;
    localparam int SH_W  = PAY_B * 8;
    localparam int BUS_W = NUM_SB * 6;
    localparam int CNT_W = (PAY_B > 1) ? $clog2(PAY_B) : 1;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAY_B - 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LOAD = 2'd1,
        CHK  = 2'd2,
        CMT  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [7:0]         xor_q,   xor_d;
    logic [SH_W-1:0]    shadow_q, shadow_d;
    logic               match_q, match_d;
    logic [BUS_W-1:0]   dir_q,   dir_d;
    logic [BUS_W-1:0]   en_q,    en_d;
    logic               done_q,  done_d;
    logic               err_q,   err_d;

    logic               rb_busy;
    logic               cfg_xfer;

`ifdef SB_CFG_READBACK_EN
    logic               rb_active_q;
    assign rb_busy = rb_active_q;
`else
    assign rb_busy = 1'b0;
`endif

    // The commit cycle is a one-cycle bubble; readback also stalls the loader.
    assign cfg_ready = (state_q != CMT) && !rb_busy;
    assign cfg_xfer  = cfg_valid && cfg_ready;

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one
        // unassigned; otherwise synthesis would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        xor_d    = xor_q;
        shadow_d = shadow_q;
        match_d  = match_q;
        dir_d    = dir_q;
        en_d     = en_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (cfg_abort) begin
            // Abort wins over any transfer in the same cycle, including a
            // commit: the buses keep their last committed value.
            state_d = HUNT;
            cnt_d   = '0;
            xor_d   = '0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (cfg_xfer && (cfg_data == SYNC)) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                        xor_d   = '0;
                    end
                end
                LOAD: begin
                    // A SYNC value here is ordinary payload; only the
                    // checksum guards against misframing.
                    if (cfg_xfer) begin
                        shadow_d[8*int'(cnt_q) +: 8] = cfg_data;
                        xor_d                        = xor_q ^ cfg_data;
                        if (cnt_q == LAST_BYTE) begin
                            state_d = CHK;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                CHK: begin
                    if (cfg_xfer) begin
                        match_d = (cfg_data == xor_q);
                        state_d = CMT;
                    end
                end
                CMT: begin
                    // All boxes load on the same edge, so no partial frame
                    // is ever visible on the buses.
                    if (match_q) begin
                        for (int k = 0; k < NUM_SB; k++) begin
                            dir_d[6*k +: 6] = shadow_q[12*k     +: 6];
                            en_d[6*k +: 6]  = shadow_q[12*k + 6 +: 6];
                        end
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = HUNT;
                    cnt_d   = '0;
                    xor_d   = '0;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            cnt_q    <= '0;
            xor_q    <= '0;
            shadow_q <= '0;
            match_q  <= 1'b0;
            dir_q    <= '0;
            en_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            xor_q    <= xor_d;
            shadow_q <= shadow_d;
            match_q  <= match_d;
            dir_q    <= dir_d;
            en_q     <= en_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign dir_bus  = dir_q;
    assign en_bus   = en_q;
    assign cfg_done = done_q;
    assign cfg_err  = err_q;

`ifdef SB_CFG_READBACK_EN
    // -------------------------------------------------------------------------
    // Readback: snapshot the committed buses and stream them out in the same
    // packing as the load frame, followed by the XOR checksum.
    // -------------------------------------------------------------------------
    localparam int RB_CNT_W = $clog2(PAY_B + 1);
    localparam logic [RB_CNT_W-1:0] RB_CHK = RB_CNT_W'(PAY_B);

    function automatic logic [SH_W-1:0] pack_buses(input logic [BUS_W-1:0] d,
                                                   input logic [BUS_W-1:0] e);
        logic [SH_W-1:0] p;
        p = '0;
        for (int k = 0; k < NUM_SB; k++) begin
            p[12*k     +: 6] = d[6*k +: 6];
            p[12*k + 6 +: 6] = e[6*k +: 6];
        end
        return p;
    endfunction

    logic                rb_active_d;
    logic [RB_CNT_W-1:0] rb_cnt_q, rb_cnt_d;
    logic [7:0]          rb_xor_q, rb_xor_d;
    logic [SH_W-1:0]     rb_snap_q, rb_snap_d;
    logic                rb_start;
    logic                rb_xfer;

    assign rb_start = rb_req && !rb_active_q && (state_q == HUNT);
    assign rb_valid = rb_active_q;
    assign rb_xfer  = rb_active_q && rb_ready;

    always_comb begin
        rb_data = rb_xor_q;
        if (rb_cnt_q != RB_CHK) begin
            rb_data = rb_snap_q[8*int'(rb_cnt_q) +: 8];
        end
    end

    always_comb begin
        rb_active_d = rb_active_q;
        rb_cnt_d    = rb_cnt_q;
        rb_xor_d    = rb_xor_q;
        rb_snap_d   = rb_snap_q;

        if (rb_start) begin
            rb_active_d = 1'b1;
            rb_cnt_d    = '0;
            rb_xor_d    = '0;
            rb_snap_d   = pack_buses(dir_q, en_q);
        end else if (rb_xfer) begin
            if (rb_cnt_q == RB_CHK) begin
                rb_active_d = 1'b0;
            end else begin
                rb_xor_d = rb_xor_q ^ rb_data;
                rb_cnt_d = rb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_active_q <= 1'b0;
            rb_cnt_q    <= '0;
            rb_xor_q    <= '0;
            rb_snap_q   <= '0;
        end else begin
            rb_active_q <= rb_active_d;
            rb_cnt_q    <= rb_cnt_d;
            rb_xor_q    <= rb_xor_d;
            rb_snap_q   <= rb_snap_d;
        end
    end
`endif

endmodule

// File: tb/tb_sb_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_sb_cfg_loader
//
// Directed bench for sb_cfg_loader (NUM_SB=4, PAY_B=6). Inputs are driven 1ns
// after the rising edge and outputs are sampled at the same point, away from
// the active edge. cfg_done/cfg_err pulses are also counted on falling edges.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sb_cfg_loader;

    localparam int NUM_SB = 4;
    localparam int BUS_W  = NUM_SB * 6;

    logic              clk;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [7:0]        cfg_data;
    logic              cfg_abort;
    logic [BUS_W-1:0]  dir_bus;
    logic [BUS_W-1:0]  en_bus;
    logic              cfg_done;
    logic              cfg_err;
`ifdef SB_CFG_READBACK_EN
    logic              rb_req;
    logic              rb_valid;
    logic              rb_ready;
    logic [7:0]        rb_data;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int err_cnt      = 0;

    sb_cfg_loader #(.NUM_SB(NUM_SB), .SYNC(8'hA5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_abort (cfg_abort),
        .dir_bus   (dir_bus),
        .en_bus    (en_bus),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
`ifdef SB_CFG_READBACK_EN
        ,
        .rb_req    (rb_req),
        .rb_valid  (rb_valid),
        .rb_ready  (rb_ready),
        .rb_data   (rb_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_done) done_cnt++;
        if (cfg_err)  err_cnt++;
    end

    // Frame payloads (byte 0 in bits [7:0]) with hand-computed checksums
    // and the bus values they must produce.
    localparam logic [47:0] F1_PAY = 48'h0000_0000_0400; // en box0 = 6'b010000
    localparam logic [7:0]  F1_CHK = 8'h04;
    localparam logic [47:0] F2_PAY = 48'h0000_000C_3000; // box1 dir=en=6'b000011
    localparam logic [7:0]  F2_CHK = 8'h3C;
    localparam logic [47:0] F3_PAY = 48'hFEA0_0000_0000; // box3 dir=2A en=3F
    localparam logic [7:0]  F3_CHK = 8'h5E;
    localparam logic [47:0] F4_PAY = 48'h0000_0000_00A5; // SYNC as payload
    localparam logic [7:0]  F4_CHK = 8'hA5;

    // Drive one byte and wait (bounded) until it transfers.
    task automatic send(input logic [7:0] b);
        int n;
        cfg_valid = 1'b1;
        cfg_data  = b;
        n = 0;
        while (!cfg_ready && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 16) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: cfg_ready=%b required 1 within 16 cycles", cfg_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [47:0] pay, input logic [7:0] chk);
        send(8'hA5);
        for (int i = 0; i < 6; i++) send(pay[8*i +: 8]);
        send(chk);
    endtask

    task automatic idle(input int n);
        cfg_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        cfg_abort = 1'b0;
`ifdef SB_CFG_READBACK_EN
        rb_req    = 1'b0;
        rb_ready  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (dir_bus !== 24'h0) begin tests_failed++; $display("FAIL reset_dir: got %h required %h", dir_bus, 24'h0); end
        tests_run++;
        if (en_bus !== 24'h0) begin tests_failed++; $display("FAIL reset_en: got %h required %h", en_bus, 24'h0); end
        tests_run++;
        if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b required 1", cfg_ready); end
        tests_run++;
        if (cfg_done !== 1'b0 || cfg_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_pulses: done=%b err=%b required 0 0", cfg_done, cfg_err);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_good_frame();
        send_frame(F1_PAY, F1_CHK);
        cfg_valid = 1'b0;
        // CMT cycle: bubble, nothing visible yet.
        tests_run++;
        if (cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL good_cmt_ready: got %b required 0", cfg_ready); end
        tests_run++;
        if (cfg_done !== 1'b0 || en_bus !== 24'h0) begin
            tests_failed++; $display("FAIL good_early: done=%b en=%h required 0 000000", cfg_done, en_bus);
        end
        @(posedge clk); #1;
        tests_run++;
        if (cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
            tests_failed++; $display("FAIL good_pulse: done=%b err=%b required 1 0", cfg_done, cfg_err);
        end
        tests_run++;
        if (en_bus !== 24'h000010 || dir_bus !== 24'h0) begin
            tests_failed++; $display("FAIL good_bus: en=%h dir=%h required 000010 000000", en_bus, dir_bus);
        end
        @(posedge clk); #1;
        tests_run++;
        if (cfg_done !== 1'b0 || cfg_ready !== 1'b1) begin
            tests_failed++; $display("FAIL good_after: done=%b ready=%b required 0 1", cfg_done, cfg_ready);
        end
    endtask

    task automatic test_bad_checksum();
        int d0;
        d0 = done_cnt;
        send_frame(F1_PAY, 8'h05);
        idle(1);
        tests_run++;
        if (cfg_err !== 1'b1 || cfg_done !== 1'b0) begin
            tests_failed++; $display("FAIL bad_pulse: err=%b done=%b required 1 0", cfg_err, cfg_done);
        end
        tests_run++;
        if (en_bus !== 24'h000010 || dir_bus !== 24'h0) begin
            tests_failed++; $display("FAIL bad_bus: en=%h dir=%h required 000010 000000", en_bus, dir_bus);
        end
        idle(1);
        tests_run++;
        if (done_cnt != d0 || cfg_err !== 1'b0) begin
            tests_failed++; $display("FAIL bad_count: done_delta=%0d err=%b required 0 0", done_cnt - d0, cfg_err);
        end
    endtask

    task automatic test_junk();
        int d0;
        d0 = done_cnt;
        send(8'h3C);
        send(8'h11);
        send_frame(F2_PAY, F2_CHK);
        idle(2);
        tests_run++;
        if (done_cnt != d0 + 1) begin tests_failed++; $display("FAIL junk_done: got %0d required 1", done_cnt - d0); end
        tests_run++;
        if (dir_bus !== 24'h0000C0 || en_bus !== 24'h0000C0) begin
            tests_failed++; $display("FAIL junk_bus: dir=%h en=%h required 0000c0 0000c0", dir_bus, en_bus);
        end
    endtask

    task automatic test_abort();
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hA5);
        send(8'h00); send(8'h04); send(8'h00);
        // Abort together with a valid byte: the byte must be dropped.
        cfg_abort = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h77;
        @(posedge clk); #1;
        cfg_abort = 1'b0;
        send(8'h00); send(8'h00); send(8'h00); send(8'h04);
        // Abort with SYNC on the bus: the SYNC must be dropped too, so the
        // all-zero frame that follows must not commit.
        cfg_abort = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hA5;
        @(posedge clk); #1;
        cfg_abort = 1'b0;
        for (int i = 0; i < 7; i++) send(8'h00);
        idle(2);
        tests_run++;
        if (done_cnt != d0 || err_cnt != e0) begin
            tests_failed++; $display("FAIL abort_pulses: done_delta=%0d err_delta=%0d required 0 0", done_cnt - d0, err_cnt - e0);
        end
        tests_run++;
        if (dir_bus !== 24'h0000C0 || en_bus !== 24'h0000C0) begin
            tests_failed++; $display("FAIL abort_bus: dir=%h en=%h required 0000c0 0000c0", dir_bus, en_bus);
        end
    endtask

    task automatic test_sync_payload();
        int d0;
        d0 = done_cnt;
        send_frame(F4_PAY, F4_CHK);
        idle(2);
        tests_run++;
        if (done_cnt != d0 + 1 || dir_bus !== 24'h000025 || en_bus !== 24'h000002) begin
            tests_failed++; $display("FAIL sync_payload: done_delta=%0d dir=%h en=%h required 1 000025 000002", done_cnt - d0, dir_bus, en_bus);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        send_frame(F2_PAY, F2_CHK);
        // Next SYNC presented while the loader sits in its commit bubble.
        cfg_valid = 1'b1; cfg_data = 8'hA5;
        tests_run++;
        if (cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_stall: ready=%b required 0", cfg_ready); end
        send_frame(F3_PAY, F3_CHK);
        idle(2);
        tests_run++;
        if (done_cnt != d0 + 2) begin tests_failed++; $display("FAIL b2b_done: got %0d required 2", done_cnt - d0); end
        tests_run++;
        if (dir_bus !== 24'hA80000 || en_bus !== 24'hFC0000) begin
            tests_failed++; $display("FAIL b2b_bus: dir=%h en=%h required a80000 fc0000", dir_bus, en_bus);
        end
    endtask

    task automatic test_reset_mid_load();
        int d0;
        send(8'hA5);
        send(8'h12);
        send(8'h34);
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        tests_run++;
        if (dir_bus !== 24'h0 || en_bus !== 24'h0) begin
            tests_failed++; $display("FAIL async_reset: dir=%h en=%h required 000000 000000", dir_bus, en_bus);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        d0 = done_cnt;
        send_frame(F1_PAY, F1_CHK);
        idle(2);
        tests_run++;
        if (done_cnt != d0 + 1 || en_bus !== 24'h000010 || dir_bus !== 24'h0) begin
            tests_failed++; $display("FAIL post_reset_frame: done_delta=%0d en=%h dir=%h required 1 000010 000000", done_cnt - d0, en_bus, dir_bus);
        end
    endtask

`ifdef SB_CFG_READBACK_EN
    task automatic test_readback();
        logic [7:0] exp_b [7];
        logic [7:0] got_b [7];
        int n, cyc;
        exp_b = '{8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04};
        rb_req = 1'b1;
        @(posedge clk); #1;
        rb_req = 1'b0;
        tests_run++;
        if (rb_valid !== 1'b1 || cfg_ready !== 1'b0) begin
            tests_failed++; $display("FAIL rb_start: valid=%b ready=%b required 1 0", rb_valid, cfg_ready);
        end
        n = 0;
        cyc = 0;
        while (n < 7 && cyc < 64) begin
            rb_ready = cyc[0];
            @(negedge clk);
            if (rb_valid && rb_ready) begin
                got_b[n] = rb_data;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        rb_ready = 1'b0;
        tests_run++;
        if (n != 7) begin tests_failed++; $display("FAIL rb_count: got %0d bytes required 7", n); end
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (got_b[i] !== exp_b[i]) begin
                tests_failed++; $display("FAIL rb_byte%0d: got %h required %h", i, got_b[i], exp_b[i]);
            end
        end
        tests_run++;
        if (rb_valid !== 1'b0 || cfg_ready !== 1'b1) begin
            tests_failed++; $display("FAIL rb_end: valid=%b ready=%b required 0 1", rb_valid, cfg_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_junk();
        test_abort();
        test_sync_payload();
        test_back_to_back();
        test_reset_mid_load();
`ifdef SB_CFG_READBACK_EN
        test_readback();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
